reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_if.sv | 28 ++
 rtl/reg_bank_rport.sv | 60 ++++++
 rtl/reg_bank.sv | 75 +++++++
 tb/tb_reg_bank.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank and the ALU that consumes it.
// Build option REG_BANK_BYPASS_EN (used by the read ports) selects write-first forwarding.
package reg_bank_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Keeps a one-entry bank from collapsing the index width to zero bits.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W   = addr_width(NUM_REGS);
  localparam int ZERO_REG = 0;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_bank_if.sv
// Read/write bus between the datapath (master) and the register bank (slave).
// Build option REG_BANK_BYPASS_EN changes bank behaviour only, not this bus.
interface reg_bank_if
  #(parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, rd_valid, wr_done
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, rd_valid, wr_done
  );

endinterface

// File: rtl/reg_bank_rport.sv
// One registered read port of the register bank: index mux, zero/out-of-range rule.
// With REG_BANK_BYPASS_EN defined a same-cycle write is forwarded (write-first).
module reg_bank_rport
  #(parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int NUM_REGS = reg_bank_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W)
  (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rd_en_i,
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
    output logic [DATA_W-1:0]                rd_data_o
  );

  import reg_bank_pkg::*;

  logic [DATA_W-1:0] rdData_d;
  logic [DATA_W-1:0] rdData_q;
  logic              addrLive;

  // Register 0 and indices past the end of the bank always read as zero.
  assign addrLive = (rd_addr_i != ADDR_W'(ZERO_REG)) &&
                    ({1'b0, rd_addr_i} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    rdData_d = rdData_q;
    if (rd_en_i) begin
      if (!addrLive) begin
        rdData_d = '0;
      end else begin
        rdData_d = regs_i[rd_addr_i];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
          rdData_d = wr_data_i;
        end
`endif
      end
    end
  end

`ifndef REG_BANK_BYPASS_EN
  logic unusedWrPath;
  assign unusedWrPath = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= rdData_d;
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/reg_bank.sv
// Two-read/one-write register bank with one-cycle registered reads and a write-done pulse.
// Define REG_BANK_BYPASS_EN for write-first same-cycle forwarding; default is read-first.
module reg_bank
  #(parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int NUM_REGS = reg_bank_pkg::NUM_REGS)
  (
    input  logic      clk,
    input  logic      rst_n,
    reg_bank_if.slave bus
  );

  import reg_bank_pkg::*;

  localparam int ADDR_W = addr_width(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regFile_q;
  logic                            rdValid_q;
  logic                            wrDone_q;
  logic                            wrAccept;
  logic [DATA_W-1:0]               rdData1;
  logic [DATA_W-1:0]               rdData2;

  // Writes to register 0 or beyond the bank are dropped and never signal completion.
  assign wrAccept = bus.wr_en &&
                    (bus.wr_addr != ADDR_W'(ZERO_REG)) &&
                    ({1'b0, bus.wr_addr} < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regFile_q <= '0;
    end else if (wrAccept) begin
      regFile_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdValid_q <= 1'b0;
      wrDone_q  <= 1'b0;
    end else begin
      rdValid_q <= bus.rd_en;
      wrDone_q  <= wrAccept;
    end
  end

  reg_bank_rport #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rport1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (bus.rd_en),
    .rd_addr_i (bus.rd_addr1),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .regs_i    (regFile_q),
    .rd_data_o (rdData1)
  );

  reg_bank_rport #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rport2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (bus.rd_en),
    .rd_addr_i (bus.rd_addr2),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .regs_i    (regFile_q),
    .rd_data_o (rdData2)
  );

  assign bus.rd_data1 = rdData1;
  assign bus.rd_data2 = rdData2;
  assign bus.rd_valid = rdValid_q;
  assign bus.wr_done  = wrDone_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank against an array model of the register file.
// Honours REG_BANK_BYPASS_EN the same way the design build does.
module tb_reg_bank;

  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_bank_if bus ();

  reg_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [NUM_REGS];
  logic [31:0] exp1;
  logic [31:0] exp2;
  logic        expValid;
  logic        expDone;

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    exp1     = 32'h0;
    exp2     = 32'h0;
    expValid = 1'b0;
    expDone  = 1'b0;
  endtask

  // Value a read of index a returns, given the write presented in the same cycle.
  function automatic logic [31:0] predict(input int a, input logic we, input int wa,
                                          input logic [31:0] wd);
    if (a == 0 || a >= NUM_REGS) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return model[a];
  endfunction

  task automatic step(input logic re, input int a1, input int a2,
                      input logic we, input int wa, input logic [31:0] wd);
    bus.rd_en    = re;
    bus.rd_addr1 = a1[ADDR_W-1:0];
    bus.rd_addr2 = a2[ADDR_W-1:0];
    bus.wr_en    = we;
    bus.wr_addr  = wa[ADDR_W-1:0];
    bus.wr_data  = wd;
    if (re) begin
      exp1 = predict(a1, we, wa, wd);
      exp2 = predict(a2, we, wa, wd);
    end
    expValid = re;
    expDone  = we && (wa != 0) && (wa < NUM_REGS);
    if (expDone) model[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset rd_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_data1 !== 32'h0) begin errors++; $display("[TB] FAIL reset rd_data1 got %h exp 0", bus.rd_data1); end
    checks++; if (bus.rd_data2 !== 32'h0) begin errors++; $display("[TB] FAIL reset rd_data2 got %h exp 0", bus.rd_data2); end
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("[TB] FAIL reset wr_done got %b exp 0", bus.wr_done); end
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_read();
    step(1'b1, 5, 9, 1'b0, 0, 32'h0);
    checks++; if (bus.rd_data1 !== exp1) begin errors++; $display("[TB] FAIL first_read rd_data1 got %h exp %h", bus.rd_data1, exp1); end
    checks++; if (bus.rd_data2 !== exp2) begin errors++; $display("[TB] FAIL first_read rd_data2 got %h exp %h", bus.rd_data2, exp2); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_read rd_valid got %b exp 1", bus.rd_valid); end
  endtask

  task automatic test_write_read();
    step(1'b0, 0, 0, 1'b1, 7, 32'hDEADBEEF);
    checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("[TB] FAIL write_r7 wr_done got %b exp 1", bus.wr_done); end
    step(1'b1, 7, 0, 1'b0, 0, 32'h0);
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("[TB] FAIL write_r7 wr_done_pulse got %b exp 0", bus.wr_done); end
    checks++; if (bus.rd_data1 !== 32'hDEADBEEF || bus.rd_data1 !== exp1) begin errors++; $display("[TB] FAIL read_r7 rd_data1 got %h exp %h", bus.rd_data1, exp1); end
    checks++; if (bus.rd_data2 !== exp2) begin errors++; $display("[TB] FAIL read_r0 rd_data2 got %h exp %h", bus.rd_data2, exp2); end
  endtask

  task automatic test_zero_write();
    step(1'b0, 0, 0, 1'b1, 0, 32'h12345678);
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("[TB] FAIL zero_write wr_done got %b exp 0", bus.wr_done); end
    step(1'b1, 0, 0, 1'b0, 0, 32'h0);
    checks++; if (bus.rd_data1 !== 32'h0) begin errors++; $display("[TB] FAIL zero_read rd_data1 got %h exp 0", bus.rd_data1); end
    checks++; if (bus.rd_data2 !== 32'h0) begin errors++; $display("[TB] FAIL zero_read rd_data2 got %h exp 0", bus.rd_data2); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
`ifdef REG_BANK_BYPASS_EN
    want = 32'h0000000B;
`else
    want = 32'h0000000A;
`endif
    step(1'b0, 0, 0, 1'b1, 3, 32'h0000000A);
    step(1'b1, 3, 3, 1'b1, 3, 32'h0000000B);
    checks++; if (bus.rd_data1 !== want || exp1 !== want) begin errors++; $display("[TB] FAIL same_cycle rd_data1 got %h exp %h", bus.rd_data1, want); end
    checks++; if (bus.rd_data2 !== want) begin errors++; $display("[TB] FAIL same_cycle rd_data2 got %h exp %h", bus.rd_data2, want); end
    checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle wr_done got %b exp 1", bus.wr_done); end
    step(1'b1, 3, 3, 1'b0, 0, 32'h0);
    checks++; if (bus.rd_data1 !== 32'h0000000B) begin errors++; $display("[TB] FAIL after_same rd_data1 got %h exp 0000000b", bus.rd_data1); end
    checks++; if (bus.rd_data2 !== 32'h0000000B) begin errors++; $display("[TB] FAIL after_same rd_data2 got %h exp 0000000b", bus.rd_data2); end
  endtask

  task automatic test_hold();
    step(1'b1, 7, 3, 1'b0, 0, 32'h0);
    step(1'b0, 1, 2, 1'b1, 7, 32'h55AA55AA);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold rd_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_data1 !== exp1) begin errors++; $display("[TB] FAIL hold rd_data1 got %h exp %h", bus.rd_data1, exp1); end
    checks++; if (bus.rd_data2 !== exp2) begin errors++; $display("[TB] FAIL hold rd_data2 got %h exp %h", bus.rd_data2, exp2); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) step(1'b0, 0, 0, 1'b1, i, i);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, i, 0, 1'b0, 0, 32'h0);
      checks++; if (bus.rd_data1 !== 32'(i) || bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL back_to_back[%0d] rd_data1/rd_valid got %h/%b exp %h/1", i, bus.rd_data1, bus.rd_valid, 32'(i)); end
    end
  endtask

  task automatic test_random();
    int a1, a2, wa;
    logic re, we;
    logic [31:0] wd;
    for (int n = 0; n < 300; n++) begin
      re = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0);
      a1 = $urandom_range(0, NUM_REGS - 1);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, NUM_REGS - 1);
      wa = ($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, NUM_REGS - 1);
      wd = $urandom;
      step(re, a1, a2, we, wa, wd);
      checks++; if (bus.rd_data1 !== exp1) begin errors++; $display("[TB] FAIL random[%0d] rd_data1 got %h exp %h", n, bus.rd_data1, exp1); end
      checks++; if (bus.rd_data2 !== exp2) begin errors++; $display("[TB] FAIL random[%0d] rd_data2 got %h exp %h", n, bus.rd_data2, exp2); end
      checks++; if (bus.rd_valid !== expValid) begin errors++; $display("[TB] FAIL random[%0d] rd_valid got %b exp %b", n, bus.rd_valid, expValid); end
      checks++; if (bus.wr_done !== expDone) begin errors++; $display("[TB] FAIL random[%0d] wr_done got %b exp %b", n, bus.wr_done, expDone); end
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b0, 0, 0, 1'b1, 4, 32'hFFFFFFFF);
    step(1'b1, 4, 4, 1'b0, 0, 32'h0);
    checks++; if (bus.rd_data1 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL pre_reset rd_data1 got %h exp ffffffff", bus.rd_data1); end
    bus.rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset rd_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_data1 !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset rd_data1 got %h exp 0", bus.rd_data1); end
    checks++; if (bus.rd_data2 !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset rd_data2 got %h exp 0", bus.rd_data2); end
    clear_model();
    #1;
    rst_n = 1'b1;
    step(1'b1, 4, 4, 1'b0, 0, 32'h0);
    checks++; if (bus.rd_data1 !== 32'h0 || bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset r4 rd_data1/rd_valid got %h/%b exp 0/1", bus.rd_data1, bus.rd_valid); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_zero_write();
    test_same_cycle();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
